// File: rtl/sw_led_ctrl_if.sv
// ---------------------------------------------------------------------------
// sw_led_ctrl_if
//   Board-side bundle for the switch-to-LED controller.
//
//   sw     raw switch pins (asynchronous to clk)
//   mode   per-channel LED mode, bits [2i+1:2i] for channel i
//            00 direct, 01 inverted, 10 toggle, 11 blink
//   led    registered LED drive
//   sw_db  debounced switch level
//   rise   one-cycle pulse on a debounced 0->1 edge
//
//   master : the side that owns the pins/config (board glue, bench)
//   slave  : sw_led_ctrl
// ---------------------------------------------------------------------------
interface sw_led_ctrl_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   sw;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   led;
    logic [N_CH-1:0]   sw_db;
    logic [N_CH-1:0]   rise;

    modport master (
        output sw,
        output mode,
        input  led,
        input  sw_db,
        input  rise
    );

    modport slave (
        input  sw,
        input  mode,
        output led,
        output sw_db,
        output rise
    );
endinterface

// File: rtl/sw_led_ctrl.sv
// ---------------------------------------------------------------------------
// sw_led_ctrl
//   Parametrised switch-to-LED controller. Each channel synchronises its raw
//   switch, debounces it, exports the debounced level plus a rise pulse, keeps
//   a press-toggled bit, and drives its LED from one of four modes.
//
//   Build option: define SW_LED_BLINK_EN to include the shared blink
//   prescaler. Without it, mode 11 behaves as direct and BLINK_HALF is
//   ignored.
//
//   Parameters
//     N_CH        number of channels (1..16)
//     DEB_CYCLES  consecutive disagreeing synchronised samples needed to
//                 accept a switch change (>=2)
//     BLINK_HALF  clocks per blink half-period (>=2, blink build only)
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset; every flop clears
//     bus    sw_led_ctrl_if.slave (sw, mode in; led, sw_db, rise out)
// ---------------------------------------------------------------------------

// Per-channel datapath: 2-flop synchroniser, debouncer, rise pulse,
// toggle bit and LED register.
module sw_led_lane #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw,
`ifdef SW_LED_BLINK_EN
    input  logic       phase,
`endif
    input  logic [1:0] mode,
    output logic       sw_db,
    output logic       rise,
    output logic       led
);
    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_INV    = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sw_db_q, sw_db_d;
    logic             rise_q, rise_d;
    logic             t_q, t_d;
    logic             led_q, led_d;

    always_comb begin
        s1_d    = sw;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        sw_db_d = sw_db_q;
        rise_d  = 1'b0;
        t_d     = t_q;

        // The counter only advances while the synchronised input disagrees
        // with the accepted level; any agreement restarts the qualification.
        if (s2_q == sw_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            sw_db_d = s2_q;
            cnt_d   = '0;
            if (s2_q) begin
                rise_d = 1'b1;
                t_d    = ~t_q;   // toggle tracks presses in every mode
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // LED is built from the current (pre-edge) sources, so it follows
        // sw_db / t / phase by one clock.
        unique case (mode)
            MODE_DIRECT: led_d = sw_db_q;
            MODE_INV:    led_d = ~sw_db_q;
            MODE_TOGGLE: led_d = t_q;
`ifdef SW_LED_BLINK_EN
            default:     led_d = sw_db_q & phase;
`else
            default:     led_d = sw_db_q;
`endif
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            sw_db_q <= 1'b0;
            rise_q  <= 1'b0;
            t_q     <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            sw_db_q <= sw_db_d;
            rise_q  <= rise_d;
            t_q     <= t_d;
            led_q   <= led_d;
        end
    end

    assign sw_db = sw_db_q;
    assign rise  = rise_q;
    assign led   = led_q;
endmodule

module sw_led_ctrl #(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 16,
    parameter int BLINK_HALF = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    sw_led_ctrl_if.slave bus
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [N_CH-1:0] sw_db_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] led_w;

`ifdef SW_LED_BLINK_EN
    // Shared blink prescaler: counts 0..BLINK_HALF-1 and flips the phase on
    // each wrap, so the first flip lands on edge BLINK_HALF after release.
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_HALF - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (bcnt_q == BCNT_MAX) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    // Blink period has no meaning in this build.
    logic blink_half_unused;
    assign blink_half_unused = (BLINK_HALF != 0);
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        sw_led_lane #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .sw    (bus.sw[i]),
`ifdef SW_LED_BLINK_EN
            .phase (phase_q),
`endif
            .mode  (bus.mode[2*i +: 2]),
            .sw_db (sw_db_w[i]),
            .rise  (rise_w[i]),
            .led   (led_w[i])
        );
    end

    assign bus.sw_db = sw_db_w;
    assign bus.rise  = rise_w;
    assign bus.led   = led_w;
endmodule
